// File: rtl/seq_encoder_if.sv
// Handshake bundle for seq_encoder: an input word stream and an output index stream.
// The slave modport is the encoder's side. The master modport is the producer/consumer side.
interface seq_encoder_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic [WIDTH-1:0] inData;
  logic             inValid;
  logic             inReady;
  logic [IDX_W-1:0] outData;
  logic             outValid;
  logic             outReady;
  logic             outLast;
  logic             outEmpty;
  logic [IDX_W:0]   outSeq;

  modport slave (
    input  inData, inValid, outReady,
    output inReady, outData, outValid, outLast, outEmpty, outSeq
  );

  modport master (
    output inData, inValid, outReady,
    input  inReady, outData, outValid, outLast, outEmpty, outSeq
  );
endinterface

// File: rtl/seq_encoder.sv
// Sequential multi-hot to index encoder.
// The encoder accepts one word, then emits the index of each set bit, lowest index first.
// An all-zero word produces one beat with outEmpty set.
//
// state | meaning
// IDLE  | waiting for a word; inReady high
// EMIT  | streaming indices of pending bits; input held off
module seq_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input logic          clk,
  input logic          rst_n,
  seq_encoder_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pending_q;
  logic [IDX_W-1:0] data_q;
  logic             valid_q;
  logic             last_q;
  logic             empty_q;
  logic [IDX_W:0]   seq_q;

  logic [WIDTH-1:0] pending_d;
  logic [IDX_W-1:0] idx_d;
  logic             in_fire;
  logic             out_fire;

  // The fixed priority encoder returns the lowest set bit. It returns 0 when no bit is set.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    lowest_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  // This is true when at most one bit is set. A zero word is also treated as its own last beat.
  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    at_most_one = ((v & (v - WIDTH'(1))) == '0);
  endfunction

  assign in_fire  = bus.inValid && bus.inReady;
  assign out_fire = valid_q && bus.outReady;

  // Clearing the lowest set bit removes exactly the bit that is being emitted now.
  assign pending_d = pending_q & (pending_q - WIDTH'(1));
  assign idx_d     = lowest_idx(pending_d);

  // Word capture, beat sequencing and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      empty_q   <= 1'b0;
      seq_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            pending_q <= bus.inData;
            data_q    <= lowest_idx(bus.inData);
            last_q    <= at_most_one(bus.inData);
            empty_q   <= (bus.inData == '0);
            seq_q     <= '0;
            valid_q   <= 1'b1;
            state_q   <= EMIT;
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (last_q) begin
              state_q   <= IDLE;
              pending_q <= '0;
              data_q    <= '0;
              valid_q   <= 1'b0;
              last_q    <= 1'b0;
              empty_q   <= 1'b0;
              seq_q     <= '0;
            end else begin
              pending_q <= pending_d;
              data_q    <= idx_d;
              last_q    <= at_most_one(pending_d);
              seq_q     <= seq_q + (IDX_W + 1)'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is gated by reset so that no word can be accepted while reset is held.
  assign bus.inReady  = rst_n && (state_q == IDLE);
  assign bus.outValid = valid_q;
  assign bus.outData  = data_q;
  assign bus.outLast  = last_q;
  assign bus.outEmpty = empty_q;
  assign bus.outSeq   = seq_q;

endmodule

// File: tb/tb_seq_encoder.sv
// Self-checking bench for seq_encoder. It uses table-driven words and a beat scoreboard.
// Hand-written sequences cover reset, backpressure and reset in the middle of a word.
module tb_seq_encoder;

  logic clk;
  logic rst_n;

  seq_encoder_if #(.WIDTH(8), .IDX_W(3)) bus ();

  seq_encoder #(.WIDTH(8), .IDX_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] d;
    logic       last;
    logic       empty;
    logic [3:0] seq;
  } beat_t;

  typedef struct {
    logic [7:0] word;
    int         beats;
    logic [2:0] first;
  } vec_t;

  beat_t sb_q[$];
  int    n_checks;
  int    n_fail;
  int    cyc;
  int    beats_seen;
  int    first_cyc;
  int    last_cyc;
  logic [2:0] first_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every set bit from the LSB upward; a zero word gives one flagged beat
  task automatic push_model(input logic [7:0] w);
    beat_t b;
    int    s;
    s = 0;
    if (w == 8'h00) begin
      b.d = 3'd0; b.last = 1'b1; b.empty = 1'b1; b.seq = 4'd0;
      sb_q.push_back(b);
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w[i]) begin
          b.d     = 3'(i);
          b.last  = ((w >> (i + 1)) == 8'h00);
          b.empty = 1'b0;
          b.seq   = 4'(s);
          sb_q.push_back(b);
          s++;
        end
      end
    end
  endtask

  task automatic monitor();
    beat_t act;
    beat_t exp;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && bus.outValid && bus.outReady) begin
        beats_seen++;
        if (beats_seen == 1) begin
          first_cyc  = cyc;
          first_data = bus.outData;
        end
        last_cyc = cyc;
        act.d = bus.outData; act.last = bus.outLast;
        act.empty = bus.outEmpty; act.seq = bus.outSeq;
        if (sb_q.size() == 0) begin
          check("unexpected_beat", 32'(act), 32'h7FFF_FFFF);
        end else begin
          exp = sb_q.pop_front();
          check("beat{data,last,empty,seq}", 32'(act), 32'(exp));
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] w);
    int k;
    @(posedge clk); #1;
    bus.inData  = w;
    bus.inValid = 1'b1;
    push_model(w);
    k = 0;
    while (!bus.inReady && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.inValid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || bus.outValid) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) begin
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h20, 1, 3'd5};
    vecs[1] = '{8'hA5, 4, 3'd0};
    vecs[2] = '{8'h00, 1, 3'd0};
    vecs[3] = '{8'hFF, 8, 3'd0};
    vecs[4] = '{8'h80, 1, 3'd7};
    vecs[5] = '{8'h5A, 4, 3'd1};
    vecs[6] = '{8'hC0, 2, 3'd6};
    vecs[7] = '{8'h01, 1, 3'd0};

    n_checks = 0; n_fail = 0; cyc = 0; beats_seen = 0;
    first_cyc = 0; last_cyc = 0; first_data = '0;
    rst_n        = 1'b0;
    bus.inData   = 8'hFF;
    bus.inValid  = 1'b1;
    bus.outReady = 1'b0;
    fork monitor(); join_none

    // Reset is held with a valid full word present.
    repeat (3) @(negedge clk);
    check("rst_inReady", 32'(bus.inReady), 32'd0);
    check("rst_outValid", 32'(bus.outValid), 32'd0);
    check("rst_outs", {bus.outData, bus.outLast, bus.outEmpty, bus.outSeq}, 32'd0);
    bus.inValid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_inReady", 32'(bus.inReady), 32'd1);
    @(posedge clk); #1;
    check("post_rst_nothing_latched", 32'(bus.outValid), 32'd0);

    // Single bit: check the first beat one clock after the word is accepted, then the return to IDLE.
    bus.outReady = 1'b1;
    beats_seen = 0;
    send(8'h20);
    check("latency_outValid", 32'(bus.outValid), 32'd1);
    check("latency_outData", 32'(bus.outData), 32'd5);
    @(posedge clk); #1;
    check("single_idle_inReady", 32'(bus.inReady), 32'd1);
    check("single_idle_outValid", 32'(bus.outValid), 32'd0);
    drain();

    // Table of words sent with the consumer always ready
    for (int v = 0; v < 8; v++) begin
      beats_seen = 0;
      send(vecs[v].word);
      drain();
      check($sformatf("beats[%0h]", vecs[v].word), 32'(beats_seen), 32'(vecs[v].beats));
      check($sformatf("first[%0h]", vecs[v].word), 32'(first_data), 32'(vecs[v].first));
      check($sformatf("nogap[%0h]", vecs[v].word), 32'(last_cyc - first_cyc + 1),
            32'(vecs[v].beats));
    end

    // Backpressure: hold the consumer off and pulse inValid while EMIT is active.
    bus.outReady = 1'b0;
    beats_seen = 0;
    send(8'h81);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold", {bus.outValid, bus.outData, bus.outSeq}, {1'b1, 3'd0, 4'd0});
      @(posedge clk); #1;
      bus.inData  = 8'h3C;
      bus.inValid = (k == 1);
    end
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    check("bp_beats", 32'(beats_seen), 32'd2);

    // Reset in the middle of a word: accept 4 and 5, then reset before 6 is taken.
    bus.outReady = 1'b0;
    beats_seen = 0;
    send(8'hF0);
    @(posedge clk); #1;
    bus.outReady = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.outReady = 1'b0;
    check("midrst_two_beats", 32'(beats_seen), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_outValid_drop", 32'(bus.outValid), 32'd0);
    check("midrst_inReady", 32'(bus.inReady), 32'd0);
    sb_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    bus.outReady = 1'b1;
    beats_seen = 0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_more_beats", 32'(beats_seen), 32'd0);
    send(8'h02);
    drain();
    check("midrst_next_beats", 32'(beats_seen), 32'd1);
    check("midrst_next_data", 32'(first_data), 32'd1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_encoder.md
Name: seq_encoder

Overview:
- Sequential 8-to-3 encoder. It is the inverse of the DC one-hot decoder: it takes a multi-hot WIDTH-bit word and emits the binary index of every set bit, one index per output beat, LSB first.
- Sits between status/request vectors and index-consuming logic, e.g. driving DC or a mux select.
- Valid/ready handshake on input and output.
- A zero word produces a single flagged beat rather than silence.

Parameters:
WIDTH, 8, input word width; power of two, >= 2
IDX_W, 3, index width; must equal clog2(WIDTH)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
inData  input  WIDTH  multi-hot word to encode
inValid  input  1  inData valid
inReady  output  1  block can accept a word
outData  output  IDX_W  index of current set bit
outValid  output  1  output beat valid
outReady  input  1  consumer accepts beat
outLast  output  1  current beat is last of the word
outEmpty  output  1  current beat represents an all-zero word
outSeq  output  IDX_W+1  beat number within the word, 0-based

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, pending=0.
  - outValid=0, outData=0, outLast=0, outEmpty=0, outSeq=0.
  - inReady forced 0 while rst_n low; inputs ignored.
- States: IDLE, EMIT.
- IDLE:
  - inReady=1, outValid=0.
  - On the edge where inValid&&inReady: latch inData into pending, outSeq<=0, state<=EMIT.
  - First beat is visible in the cycle after acceptance, so latency is 1 clock.
- EMIT:
  - inReady=0; inValid is ignored and no word is lost or latched.
  - outValid=1.
  - outData = index of the lowest set bit of pending.
  - outLast=1 when pending has exactly one bit set.
  - All out* values are registered or derived from registered state only. They hold stable while outValid&&!outReady.
- Beat acceptance (outValid&&outReady):
  - Clear the emitted bit in pending, outSeq<=outSeq+1.
  - If outLast: state<=IDLE, outSeq<=0, pending<=0.
- Zero word:
  - EMIT produces exactly one beat: outEmpty=1, outData=0, outLast=1, outSeq=0.
  - Acceptance returns to IDLE.
  - outEmpty=0 on every beat of a non-zero word.
- Throughput:
  - popcount(word) beats per word (1 for zero), plus one IDLE cycle between words.
  - A full word (all ones) gives WIDTH beats with outSeq 0..WIDTH-1; outSeq never wraps.
- outData uses a fixed LSB-first priority. Arithmetic is unsigned; indices are zero-extended to IDX_W.
- Reset mid-EMIT: all state is cleared immediately. The partial word is discarded with no further beats after rst_n deasserts. The next word is accepted normally.
- outReady held high with a single-bit word: one beat, then IDLE for 1 cycle, then inReady=1.

Test Plan:
- Reset: rst_n low with inValid=1, inData=8'hFF -> inReady=0, outValid=0, all outputs 0. After release, inReady=1 and nothing was latched.
- Single bit: inData=8'h20, outReady=1 -> one beat outData=5, outLast=1, outSeq=0, outEmpty=0, appearing 1 cycle after acceptance. Then IDLE, with inReady=1 on the following cycle.
- Multi-hot: inData=8'hA5, outReady=1 -> beats outData=0,2,5,7 with outSeq=0,1,2,3; outLast only on 7; no gaps between beats.
- Backpressure and ignored input: inData=8'h81, outReady=0 for 3 cycles. Expect outData=0 and outSeq=0 held stable; inValid pulsed during EMIT is ignored. Then outReady=1 -> beats 0 then 7(last).
- Zero and full: inData=8'h00 -> one beat outEmpty=1, outData=0, outLast=1. Then inData=8'hFF -> 8 beats, outData=0..7, outSeq=0..7, outLast on the 8th.
- Reset mid-word: inData=8'hF0, accept beats 4 and 5, then pulse rst_n low asynchronously between edges. Expect outValid to drop immediately and no beats 6/7 after release. Next word 8'h02 -> single beat outData=1, outSeq=0.
